// File: rtl/date_counter_pkg.sv
// Shared mode encodings and calendar constants for the date counter.
// Mode values match the ones the rest of the clock uses on mode1/mode2.
package date_counter_pkg;

  // Major modes (mode1)
  localparam logic [1:0] M1_TIME      = 2'd0;
  localparam logic [1:0] M1_DATE      = 2'd1;

  // Minor modes while in M1_DATE (mode2)
  localparam logic [1:0] M2_DATE_G     = 2'd0;
  localparam logic [1:0] M2_DATE_YEAR  = 2'd1;
  localparam logic [1:0] M2_DATE_MONTH = 2'd2;
  localparam logic [1:0] M2_DATE_DAY   = 2'd3;

  // Calendar limits
  localparam logic [3:0] MONTH_MIN = 4'd1;
  localparam logic [3:0] MONTH_MAX = 4'd12;
  localparam logic [4:0] DAY_MIN   = 5'd1;

endpackage

// File: rtl/date_counter_month_length.sv
// Days-in-month lookup (Gregorian, leap flag supplied by caller).
// Ports:
//   i_month  in  4  month 1..12
//   i_leap   in  1  year is a leap year
//   o_dim    out 5  number of days in that month
module date_counter_month_length (
  input  logic [3:0] i_month,
  input  logic       i_leap,
  output logic [4:0] o_dim
);

  always_comb begin
    o_dim = 5'd31;
    case (i_month)
      4'd4, 4'd6, 4'd9, 4'd11: o_dim = 5'd30;
      4'd2:                    o_dim = i_leap ? 5'd29 : 5'd28;
      default:                 o_dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// Calendar stage fed by the TIME block's day-rollover carry. Holds
// year (offset from 2000), month and day; supports manual +1 setting of
// one field at a time while in M1_DATE.
// Ports:
//   clk         in   1       system clock, rising edge
//   reset_n     in   1       synchronous reset, active low
//   hour_carry  in   1       one-clock pulse: advance one day
//   increase    in   1       one-clock pulse: +1 on field chosen by mode2
//   mode1       in   2       major mode
//   mode2       in   2       minor mode
//   year        out  YEAR_W  year offset 0..YEAR_MAX
//   month       out  4       1..12
//   day         out  5       1..days in month
//   leap        out  1       year%4==0
//   year_carry  out  1       one-clock pulse on YEAR_MAX-12-31 -> 0-01-01
module date_counter
  import date_counter_pkg::*;
#(
  parameter int YEAR_MAX = 99,
  parameter int YEAR_W   = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hour_carry,
  input  logic              increase,
  input  logic [1:0]        mode1,
  input  logic [1:0]        mode2,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic              leap,
  output logic              year_carry
);

  localparam logic [YEAR_W-1:0] YEAR_TOP = YEAR_W'(YEAR_MAX);

  logic [YEAR_W-1:0] r_year;
  logic [3:0]        r_month;
  logic [4:0]        r_day;
  logic              r_year_carry;

  logic [YEAR_W-1:0] w_year_inc;
  logic [3:0]        w_month_inc;
  logic [4:0]        w_day_inc;
  logic              w_day_wrap;
  logic              w_set;
  logic [YEAR_W-1:0] w_tgt_year;
  logic [3:0]        w_tgt_month;
  logic              w_tgt_leap;
  logic [4:0]        w_dim_cur;
  logic [4:0]        w_dim_tgt;
  logic [4:0]        w_day_clamped;

  // 2000 is a leap year, so the offset alone decides leapness in range.
  assign leap = (r_year[1:0] == 2'b00);

  assign w_year_inc  = (r_year == YEAR_TOP) ? '0 : r_year + YEAR_W'(1);
  assign w_month_inc = (r_month == MONTH_MAX) ? MONTH_MIN : r_month + 4'd1;
  assign w_day_wrap  = (r_day == w_dim_cur);
  assign w_day_inc   = w_day_wrap ? DAY_MIN : r_day + 5'd1;

  // A day advance in the same cycle swallows the set request.
  assign w_set = increase && (mode1 == M1_DATE) && !hour_carry;

  // Year/month the calendar would move to after a set, used to clamp day.
  always_comb begin
    w_tgt_year  = r_year;
    w_tgt_month = r_month;
    if (w_set && (mode2 == M2_DATE_YEAR))  w_tgt_year  = w_year_inc;
    if (w_set && (mode2 == M2_DATE_MONTH)) w_tgt_month = w_month_inc;
  end

  assign w_tgt_leap    = (w_tgt_year[1:0] == 2'b00);
  assign w_day_clamped = (r_day > w_dim_tgt) ? w_dim_tgt : r_day;

  date_counter_month_length u_dim_cur (
    .i_month (r_month),
    .i_leap  (leap),
    .o_dim   (w_dim_cur)
  );

  date_counter_month_length u_dim_tgt (
    .i_month (w_tgt_month),
    .i_leap  (w_tgt_leap),
    .o_dim   (w_dim_tgt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_year       <= '0;
      r_month      <= MONTH_MIN;
      r_day        <= DAY_MIN;
      r_year_carry <= 1'b0;
    end else begin
      r_year_carry <= 1'b0;
      if (hour_carry) begin
        r_day <= w_day_inc;
        if (w_day_wrap) begin
          r_month <= w_month_inc;
          if (r_month == MONTH_MAX) begin
            r_year       <= w_year_inc;
            r_year_carry <= (r_year == YEAR_TOP);
          end
        end
      end else if (w_set) begin
        case (mode2)
          M2_DATE_YEAR, M2_DATE_MONTH: begin
            r_year  <= w_tgt_year;
            r_month <= w_tgt_month;
            r_day   <= w_day_clamped;
          end
          M2_DATE_DAY: r_day <= w_day_inc;
          default: ;
        endcase
      end
    end
  end

  assign year       = r_year;
  assign month      = r_month;
  assign day        = r_day;
  assign year_carry = r_year_carry;

endmodule
